softmax_tile_collector: RTL and testbench

- Sits directly downstream of the self-attention head's softmax stage.
- Captures the per-row softmax tiles, which arrive on independent per-row valid strobes with no backpressure, into a frame buffer.
- Once every row is complete, drains the frame in row-major tile order over a valid/ready stream to the score-times-V multiplier input buffer.
- Flags dropped or excess tiles with sticky error bits.

---
 rtl/softmax_tile_collector_if.sv | 36 +++
 rtl/softmax_tile_collector.sv | 124 ++++++++++++
 tb/tb_softmax_tile_collector.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_tile_collector_if.sv
// Stream bundle between the softmax row lanes, the tile collector and the
// score-times-V input buffer: per-lane tile strobes in, valid/ready tile stream out.
interface softmax_tile_collector_if #(
  parameter int WIDTH         = 16,
  parameter int TILE_SIZE     = 4,
  parameter int NUM_ROWS      = 4,
  parameter int TILES_PER_ROW = 2
);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int TW = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;

  logic [TILE_SIZE*WIDTH-1:0] in_data [NUM_ROWS];
  logic                       in_valid [NUM_ROWS];
  logic                       in_ready;
  logic [TILE_SIZE*WIDTH-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [RW-1:0]              out_row;
  logic [TW-1:0]              out_tile;
  logic                       out_last;
  logic                       frame_done;
  logic                       err_drop;
  logic                       err_excess;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_row, out_tile, out_last,
           frame_done, err_drop, err_excess
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_row, out_tile, out_last,
           frame_done, err_drop, err_excess
  );
endinterface

// File: rtl/softmax_tile_collector.sv
// Collects per-row softmax tiles into a frame buffer, then drains the complete
// frame in row-major tile order over a valid/ready stream with sticky error flags.
module softmax_tile_collector #(
  parameter int WIDTH         = 16,
  parameter int TILE_SIZE     = 4,
  parameter int NUM_ROWS      = 4,
  parameter int TILES_PER_ROW = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  softmax_tile_collector_if.slave  ifc
);
  localparam int TDW = TILE_SIZE * WIDTH;
  localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int TW  = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;
  localparam int CW  = $clog2(TILES_PER_ROW + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(TILES_PER_ROW);
  localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
  localparam logic [TW-1:0] LAST_TILE = TW'(TILES_PER_ROW - 1);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    wcnt_q [NUM_ROWS];
  logic [CW-1:0]    wcnt_d [NUM_ROWS];
  logic [RW-1:0]    row_q, row_d;
  logic [TW-1:0]    tile_q, tile_d;
  logic             frame_done_q, frame_done_d;
  logic             err_drop_q, err_drop_d;
  logic             err_excess_q, err_excess_d;
  logic [TDW-1:0]   buf_q [NUM_ROWS][TILES_PER_ROW];
  logic [TDW-1:0]   buf_d [NUM_ROWS][TILES_PER_ROW];
  logic             all_full;
  logic             last_idx;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    row_d        = row_q;
    tile_d       = tile_q;
    frame_done_d = 1'b0;
    err_drop_d   = err_drop_q;
    err_excess_d = err_excess_q;
    buf_d        = buf_q;
    all_full     = 1'b1;
    last_idx     = (row_q == LAST_ROW) && (tile_q == LAST_TILE);

    // Flush aborts the frame and swallows any tiles presented with it.
    if (flush) begin
      state_d = FILL;
      row_d   = '0;
      tile_d  = '0;
      for (int r = 0; r < NUM_ROWS; r++) wcnt_d[r] = '0;
    end else if (state_q == FILL) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (ifc.in_valid[r]) begin
          if (wcnt_q[r] < FULL_CNT) begin
            for (int t = 0; t < TILES_PER_ROW; t++)
              if (wcnt_q[r] == CW'(t)) buf_d[r][t] = ifc.in_data[r];
            wcnt_d[r] = wcnt_q[r] + 1'b1;
          end else begin
            err_excess_d = 1'b1;
          end
        end
        if (wcnt_d[r] != FULL_CNT) all_full = 1'b0;
      end
      if (all_full) state_d = DRAIN;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++)
        if (ifc.in_valid[r]) err_drop_d = 1'b1;
      // Row/tile pair is the read pointer; it advances only on a handshake.
      if (ifc.out_ready) begin
        if (last_idx) begin
          state_d      = FILL;
          row_d        = '0;
          tile_d       = '0;
          frame_done_d = 1'b1;
          for (int r = 0; r < NUM_ROWS; r++) wcnt_d[r] = '0;
        end else if (tile_q == LAST_TILE) begin
          tile_d = '0;
          row_d  = row_q + 1'b1;
        end else begin
          tile_d = tile_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FILL;
      row_q        <= '0;
      tile_q       <= '0;
      frame_done_q <= 1'b0;
      err_drop_q   <= 1'b0;
      err_excess_q <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) wcnt_q[r] <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      tile_q       <= tile_d;
      frame_done_q <= frame_done_d;
      err_drop_q   <= err_drop_d;
      err_excess_q <= err_excess_d;
      for (int r = 0; r < NUM_ROWS; r++) wcnt_q[r] <= wcnt_d[r];
    end
  end

  // Frame storage carries no reset; it is only read once every lane has written it.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign ifc.in_ready   = (state_q == FILL);
  assign ifc.out_valid  = (state_q == DRAIN);
  assign ifc.out_data   = (state_q == DRAIN) ? buf_q[row_q][tile_q] : '0;
  assign ifc.out_row    = row_q;
  assign ifc.out_tile   = tile_q;
  assign ifc.out_last   = (state_q == DRAIN) && last_idx;
  assign ifc.frame_done = frame_done_q;
  assign ifc.err_drop   = err_drop_q;
  assign ifc.err_excess = err_excess_q;
endmodule

// File: tb/tb_softmax_tile_collector.sv
// Directed/randomised bench for softmax_tile_collector against a frame-level
// queue model of the collector's capture, drain and error rules.
module tb_softmax_tile_collector;
  localparam int WIDTH = 16;
  localparam int TILE_SIZE = 4;
  localparam int NR = 4;
  localparam int TPR = 2;
  localparam int TDW = WIDTH * TILE_SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  softmax_tile_collector_if #(.WIDTH(WIDTH), .TILE_SIZE(TILE_SIZE), .NUM_ROWS(NR),
                              .TILES_PER_ROW(TPR)) ifc ();

  softmax_tile_collector #(.WIDTH(WIDTH), .TILE_SIZE(TILE_SIZE), .NUM_ROWS(NR),
                           .TILES_PER_ROW(TPR)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ifc(ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TDW-1:0] data;
    int             row;
    int             tile;
  } tile_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [TDW-1:0] m_buf [NR][TPR];
  int             m_cnt [NR];
  bit             m_drain, m_done, m_drop, m_exc;
  tile_t          m_q [$];
  bit             pat_data;

  function automatic logic [TDW-1:0] pat(input int r, input int t);
    logic [15:0] e;
    e = {r[7:0], t[7:0]};
    return {4{e}};
  endfunction

  task automatic chk(input string tag, input logic [TDW-1:0] obs, input logic [TDW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_frame();
    m_drain = 1'b0;
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    m_q.delete();
  endtask

  task automatic model_apply();
    bit full;
    tile_t e;
    m_done = 1'b0;
    if (!rst_n) begin
      model_clear_frame();
      m_drop = 1'b0;
      m_exc  = 1'b0;
    end else if (flush) begin
      model_clear_frame();
    end else if (!m_drain) begin
      for (int r = 0; r < NR; r++) begin
        if (ifc.in_valid[r]) begin
          if (m_cnt[r] < TPR) begin
            m_buf[r][m_cnt[r]] = ifc.in_data[r];
            m_cnt[r]++;
          end else begin
            m_exc = 1'b1;
          end
        end
      end
      full = 1'b1;
      for (int r = 0; r < NR; r++) if (m_cnt[r] != TPR) full = 1'b0;
      if (full) begin
        m_drain = 1'b1;
        m_q.delete();
        for (int r = 0; r < NR; r++)
          for (int t = 0; t < TPR; t++) begin
            e.data = m_buf[r][t];
            e.row  = r;
            e.tile = t;
            m_q.push_back(e);
          end
      end
    end else begin
      for (int r = 0; r < NR; r++) if (ifc.in_valid[r]) m_drop = 1'b1;
      if (ifc.out_ready) begin
        m_q.delete(0);
        if (m_q.size() == 0) begin
          model_clear_frame();
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready",   TDW'(ifc.in_ready),   TDW'(!m_drain));
    chk("out_valid",  TDW'(ifc.out_valid),  TDW'(m_drain));
    chk("frame_done", TDW'(ifc.frame_done), TDW'(m_done));
    chk("err_drop",   TDW'(ifc.err_drop),   TDW'(m_drop));
    chk("err_excess", TDW'(ifc.err_excess), TDW'(m_exc));
    if (m_drain && m_q.size() > 0) begin
      chk("out_data", ifc.out_data,           m_q[0].data);
      chk("out_row",  TDW'(ifc.out_row),      TDW'(m_q[0].row));
      chk("out_tile", TDW'(ifc.out_tile),     TDW'(m_q[0].tile));
      chk("out_last", TDW'(ifc.out_last),     TDW'(m_q.size() == 1));
    end
  endtask

  // One clock: apply inputs, advance the model, sample just after the edge.
  task automatic step(input logic [NR-1:0] vmask, input logic rdy,
                      input logic fl, input logic rn);
    rst_n         = rn;
    flush         = fl;
    ifc.out_ready = rdy;
    for (int r = 0; r < NR; r++) begin
      ifc.in_valid[r] = vmask[r];
      ifc.in_data[r]  = pat_data ? pat(r, m_cnt[r]) : {$urandom, $urandom};
    end
    model_apply();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready pattern 1,0,0,...
  task automatic idle(input int n, input int mode);
    logic rdy;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (k % 3 == 0);
      endcase
      step('0, rdy, 1'b0, 1'b1);
    end
  endtask

  task automatic skewed_frame(input int mode);
    logic [NR-1:0] m;
    for (int c = 0; c <= NR; c++) begin
      for (int r = 0; r < NR; r++) m[r] = (c == r) || (c == r + 1);
      step(m, (mode == 2) ? (c % 3 == 0) : 1'b1, 1'b0, 1'b1);
    end
  endtask

  initial begin
    m_drain = 1'b0; m_done = 1'b0; m_drop = 1'b0; m_exc = 1'b0;
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    pat_data = 1'b1;
    ifc.out_ready = 1'b0;
    for (int r = 0; r < NR; r++) begin
      ifc.in_valid[r] = 1'b0;
      ifc.in_data[r]  = '0;
    end

    // Reset state
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);

    // Skewed lanes, out_ready held high
    skewed_frame(0);
    idle(10, 0);

    // Same frame with out_ready toggling 1,0,0
    skewed_frame(2);
    idle(30, 2);

    // All lanes together for two cycles, random data and random ready
    pat_data = 1'b0;
    step('1, 1'b1, 1'b0, 1'b1);
    step('1, 1'b1, 1'b0, 1'b1);
    idle(25, 1);

    // Lane 2 sends a third tile before the frame completes
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b1011, 1'b1, 1'b0, 1'b1);
    step(4'b1011, 1'b1, 1'b0, 1'b1);
    idle(10, 0);
    skewed_frame(0);
    idle(10, 0);

    // Tile arrives during drain
    step('1, 1'b0, 1'b0, 1'b1);
    step('1, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 1'b1, 1'b0, 1'b1);
    idle(10, 0);
    step('1, 1'b1, 1'b0, 1'b1);
    step('1, 1'b1, 1'b0, 1'b1);
    idle(10, 1);
    idle(10, 0);

    // Flush after five tiles, with tiles presented in the flush cycle
    step(4'b0011, 1'b0, 1'b0, 1'b1);
    step(4'b0111, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1, 1'b1);
    idle(3, 0);
    skewed_frame(0);
    idle(10, 0);

    // Reset mid-drain at p=3
    step('1, 1'b0, 1'b0, 1'b1);
    step('1, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b0);
    idle(3, 0);
    skewed_frame(1);
    idle(25, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
